instruction_fetch_queue: RTL and testbench
==========================================

Name: instruction_fetch_queue

Overview:
- Front-end fetch stage directly upstream of the RV32G instruction decoder.
- Generates sequential fetch addresses and issues in-order requests to the instruction memory port.
- Buffers returned words in a small FIFO and presents them one at a time using the decoder's active-low ready/stall handshake (n_irdy / n_stall).
- Handles PC redirects by flushing the queue and discarding in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- MAX_OUTSTANDING, 2, maximum granted-but-unreturned memory requests (1..DEPTH).
- RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0.
- imem_req  out  1  request valid.
- imem_addr  out  32  request word address.
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid; responses arrive in request order, at least 1 cycle after grant.
- imem_rdata  in  32  response data.
- imem_err  in  1  access fault for this response; qualified by imem_rvalid.
- instruction  out  32  head-entry instruction word to the decoder.
- inst_pc  out  32  address of the head entry.
- fetch_fault  out  1  head entry carries an access fault.
- n_irdy  out  1  active-low: head entry valid.
- n_stall  in  1  active-low: decoder stalls; head is consumed when n_irdy=0 and n_stall=1.

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc and resp_pc <= RESET_PC; count, inflight, discard <= 0.
  - Outputs after reset: n_irdy=1, imem_req=0, instruction=0, inst_pc=RESET_PC, fetch_fault=0.
  - Reset overrides every other input in the same cycle, including redirect, grant and response.
- Request issue:
  - imem_req = !rst && !redirect && (count + inflight < DEPTH) && (inflight < MAX_OUTSTANDING). This logic is combinational from registers.
  - imem_addr = fetch_pc.
  - On imem_req && imem_gnt: fetch_pc += 4 (wraps at 2^32); inflight += 1.
  - The slot reservation guarantees the FIFO never overflows, so no response is ever refused.
- Response:
  - Each imem_rvalid decrements inflight. Grant and response in the same cycle leave inflight unchanged.
  - If discard != 0: drop the response and decrement discard.
  - Otherwise: push {resp_pc, imem_rdata, imem_err} and set resp_pc += 4.
- Output:
  - The head entry drives instruction, inst_pc and fetch_fault combinationally.
  - n_irdy = (count == 0).
  - Pop when count != 0 && n_stall == 1.
  - Simultaneous push and pop keep count constant; push into an empty FIFO becomes visible the next cycle, so the minimum grant-to-decoder latency is 2 cycles.
  - While n_stall=0, the head and all outputs hold stable.
  - When empty, instruction and inst_pc hold their last values and fetch_fault=0. Contents are don't-care to the consumer but must be deterministic.
- Redirect (redirect=1, rst=0):
  - count <= 0; a pop in the same cycle is ignored.
  - fetch_pc and resp_pc <= {redirect_pc[31:2], 2'b00}.
  - discard <= inflight - imem_rvalid. Any response arriving this cycle is dropped, regardless of the current discard value.
  - imem_req=0 this cycle, so no grant is possible.
  - n_irdy=1 from the next cycle until the first post-redirect word is pushed.
  - Back-to-back redirects: each recomputes discard from inflight; the last target wins.
- Counters: count is clog2(DEPTH)+1 bits; inflight and discard are clog2(MAX_OUTSTANDING)+1 bits. Both are asserted never to underflow or overflow. An imem_rvalid with inflight=0 is a protocol error and is assertion-flagged.
- An access fault does not stop fetch. The faulting entry is delivered with fetch_fault=1 and the raw data; the consumer decides the trap.

Test Plan:
- Reset, then imem_gnt=1 constantly, 1-cycle response latency, rdata=addr^32'hA5A5_0000, n_stall=1 → imem_addr sequence 0,4,8,...; decoder receives inst_pc 0,4,8 back-to-back; first n_irdy=0 two cycles after the first grant.
- n_stall=0 held for 10 cycles → exactly DEPTH=4 entries are buffered; imem_req drops once count+inflight=4; the head holds inst_pc=0. Releasing the stall drains 0,4,8,12 on consecutive cycles and fetch resumes at 16.
- Two requests granted (addr 8, 12) with responses pending, then redirect to 32'h0000_1003 → both late responses are dropped; next imem_addr=32'h1000; first delivered inst_pc=32'h1000.
- Response with imem_err=1 for addr 4 → entry delivered with inst_pc=4, fetch_fault=1; the next entry (addr 8) has fetch_fault=0 and fetch continues.
- imem_gnt=0 for 5 cycles with the request pending → imem_req stays 1 and imem_addr is stable at the pending address; fetch_pc advances only on the grant cycle.
- rst asserted mid-stream with 3 queued entries and 1 in flight → next cycle n_irdy=1, imem_addr=RESET_PC, queue empty; the late response is counted against inflight=0 and flagged as an assertion failure by the bench (bench must avoid it for pass runs).

Source files
------------

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-stage bus bundle: redirect control, instruction-memory request and
// response channels, and the active-low decoder handshake.
//   master : the fetch queue (drives imem_req/addr and the decoder outputs)
//   slave  : the environment (memory, redirect source and decoder)
interface instruction_fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        fetch_fault;
  logic        n_irdy;
  logic        n_stall;

  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, imem_err, n_stall,
    output imem_req, imem_addr, instruction, inst_pc, fetch_fault, n_irdy
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, imem_err, n_stall,
    input  imem_req, imem_addr, instruction, inst_pc, fetch_fault, n_irdy
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to instruction
// memory, buffers in-order responses in a small FIFO and hands them to the
// decoder through an active-low ready/stall handshake. A redirect flushes
// the FIFO and discards responses still in flight.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - instruction_fetch_queue_if.master (redirect, imem_*, decoder side)
module instruction_fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  instruction_fetch_queue_if.master   bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0] count_reg;
  logic [OW-1:0] inflight_reg;
  logic [OW-1:0] discard_reg;
  logic [31:0]   fetch_pc_reg;
  logic [31:0]   resp_pc_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [31:0]   shown_instr_reg;
  logic [31:0]   shown_pc_reg;

  logic [31:0] mem_data [DEPTH];
  logic [31:0] mem_pc   [DEPTH];
  logic        mem_err  [DEPTH];

  logic [31:0] slots_used;
  logic        req;
  logic        grant;
  logic        push;
  logic        pop;
  logic        not_empty;
  logic [31:0] redirect_target;

  assign not_empty       = (count_reg != '0);
  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

  // Queued entries plus in-flight requests reserve FIFO slots, so a granted
  // request always has room for its response.
  assign slots_used = 32'(count_reg) + 32'(inflight_reg);
  assign req   = !rst && !bus.redirect && (slots_used < DEPTH)
                 && (32'(inflight_reg) < MAX_OUTSTANDING);
  assign grant = req && bus.imem_gnt;
  // Responses arriving in a redirect cycle are stale by definition.
  assign push  = !rst && !bus.redirect && bus.imem_rvalid && (discard_reg == '0);
  assign pop   = !rst && !bus.redirect && not_empty && bus.n_stall;

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_reg;

  // When empty the last shown word is repeated so the outputs stay deterministic.
  assign bus.instruction = not_empty ? mem_data[rd_ptr_reg] : shown_instr_reg;
  assign bus.inst_pc     = not_empty ? mem_pc[rd_ptr_reg]   : shown_pc_reg;
  assign bus.fetch_fault = not_empty && mem_err[rd_ptr_reg];
  assign bus.n_irdy      = !not_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_reg] <= bus.imem_rdata;
      mem_pc[wr_ptr_reg]   <= resp_pc_reg;
      mem_err[wr_ptr_reg]  <= bus.imem_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg       <= '0;
      inflight_reg    <= '0;
      discard_reg     <= '0;
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      shown_instr_reg <= '0;
      shown_pc_reg    <= RESET_PC;
    end else begin
      if (not_empty) begin
        shown_instr_reg <= mem_data[rd_ptr_reg];
        shown_pc_reg    <= mem_pc[rd_ptr_reg];
      end
      if (bus.redirect) begin
        count_reg    <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        fetch_pc_reg <= redirect_target;
        resp_pc_reg  <= redirect_target;
        // Everything still outstanding after this cycle belongs to the old stream.
        inflight_reg <= inflight_reg - OW'(bus.imem_rvalid);
        discard_reg  <= inflight_reg - OW'(bus.imem_rvalid);
      end else begin
        if (grant) begin
          fetch_pc_reg <= fetch_pc_reg + 32'd4;
        end
        inflight_reg <= inflight_reg + OW'(grant) - OW'(bus.imem_rvalid);
        if (bus.imem_rvalid && (discard_reg != '0)) begin
          discard_reg <= discard_reg - OW'(1);
        end
        if (push) begin
          wr_ptr_reg  <= wr_ptr_reg + PW'(1);
          resp_pc_reg <= resp_pc_reg + 32'd4;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
        count_reg <= count_reg + CW'(push) - CW'(pop);
      end
    end
  end

  // A response with nothing outstanding is a memory-side protocol error.
  rvalid_has_inflight: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid |-> (inflight_reg != '0));
  count_in_range: assert property (@(posedge clk) disable iff (rst)
    32'(count_reg) <= DEPTH);
  inflight_in_range: assert property (@(posedge clk) disable iff (rst)
    32'(inflight_reg) <= MAX_OUTSTANDING);
  discard_in_range: assert property (@(posedge clk) disable iff (rst)
    discard_reg <= inflight_reg);

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  logic [31:0] resp_q[$];
  bit          resp_en = 1'b1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  instruction_fetch_queue_if ifc();

  instruction_fetch_queue #(
    .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  // One clock step; also acts as the memory model (1-cycle response latency
  // when resp_en is set, otherwise responses are held in resp_q).
  task automatic tick();
    bit          g;
    logic [31:0] a;
    logic [31:0] r;
    #1;
    g = ifc.imem_req && ifc.imem_gnt;
    a = ifc.imem_addr;
    if (!ifc.n_irdy && ifc.n_stall && !ifc.redirect && !rst)
      $display("deliver pc=%h instr=%h fault=%b", ifc.inst_pc, ifc.instruction, ifc.fetch_fault);
    @(posedge clk);
    #1;
    if (g) resp_q.push_back(a);
    ifc.imem_rvalid = 1'b0;
    ifc.imem_rdata  = 32'h0;
    ifc.imem_err    = 1'b0;
    if (resp_en && resp_q.size() > 0) begin
      r = resp_q.pop_front();
      ifc.imem_rvalid = 1'b1;
      ifc.imem_rdata  = r ^ 32'hA5A5_0000;
      ifc.imem_err    = (r == err_addr);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.redirect = 1'b0;
    ifc.redirect_pc = 32'h0;
    ifc.imem_gnt = 1'b0;
    ifc.n_stall = 1'b1;
    ifc.imem_rvalid = 1'b0;
    ifc.imem_rdata = 32'h0;
    ifc.imem_err = 1'b0;
    resp_en = 1'b1;
    err_addr = 32'hFFFF_FFFF;
    resp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    ifc.redirect = 1'b1;
    ifc.redirect_pc = 32'h0000_4000;
    ifc.imem_gnt = 1'b1;
    tick();
    vectors++;
    if ({ifc.imem_req, ifc.n_irdy, ifc.instruction, ifc.inst_pc, ifc.fetch_fault}
        !== {1'b0, 1'b1, 32'h0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs got req=%b nirdy=%b ins=%h pc=%h ff=%b want 0 1 0 0 0",
               ifc.imem_req, ifc.n_irdy, ifc.instruction, ifc.inst_pc, ifc.fetch_fault);
    end
    ifc.redirect = 1'b0;
    ifc.imem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if ({ifc.imem_req, ifc.imem_addr, ifc.n_irdy} !== {1'b1, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_release got req=%b addr=%h nirdy=%b want 1 00000000 1",
               ifc.imem_req, ifc.imem_addr, ifc.n_irdy);
    end
  endtask

  task automatic test_stream();
    do_reset();
    ifc.imem_gnt = 1'b1;
    tick();
    vectors++;
    if ({ifc.n_irdy, ifc.imem_addr} !== {1'b1, 32'h4}) begin
      miscompares++;
      $display("FAIL stream_first got nirdy=%b addr=%h want 1 00000004", ifc.n_irdy, ifc.imem_addr);
    end
    for (int k = 2; k < 8; k++) begin
      tick();
      vectors++;
      if ({ifc.n_irdy, ifc.inst_pc, ifc.instruction, ifc.imem_addr}
          !== {1'b0, 32'(4 * (k - 2)), 32'(4 * (k - 2)) ^ 32'hA5A5_0000, 32'(4 * k)}) begin
        miscompares++;
        $display("FAIL stream_k%0d got nirdy=%b pc=%h ins=%h addr=%h want 0 %h %h %h", k,
                 ifc.n_irdy, ifc.inst_pc, ifc.instruction, ifc.imem_addr,
                 32'(4 * (k - 2)), 32'(4 * (k - 2)) ^ 32'hA5A5_0000, 32'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    do_reset();
    ifc.imem_gnt = 1'b1;
    ifc.n_stall = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i >= 2) begin
        vectors++;
        if ({ifc.n_irdy, ifc.inst_pc} !== {1'b0, 32'h0}) begin
          miscompares++;
          $display("FAIL stall_hold_c%0d got nirdy=%b pc=%h want 0 00000000", i, ifc.n_irdy, ifc.inst_pc);
        end
      end
      if (i >= 4) begin
        vectors++;
        if ({ifc.imem_req, ifc.imem_addr} !== {1'b0, 32'h10}) begin
          miscompares++;
          $display("FAIL stall_req_c%0d got req=%b addr=%h want 0 00000010", i, ifc.imem_req, ifc.imem_addr);
        end
      end
    end
    ifc.n_stall = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      tick();
      exp_pc = 32'(4 * r);
      vectors++;
      if ({ifc.n_irdy, ifc.inst_pc} !== {1'b0, exp_pc}) begin
        miscompares++;
        $display("FAIL drain_r%0d got nirdy=%b pc=%h want 0 %h", r, ifc.n_irdy, ifc.inst_pc, exp_pc);
      end
      if (r <= 2) begin
        vectors++;
        if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 32'(12 + 4 * r)}) begin
          miscompares++;
          $display("FAIL resume_r%0d got req=%b addr=%h want 1 %h", r, ifc.imem_req, ifc.imem_addr,
                   32'(12 + 4 * r));
        end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    ifc.imem_gnt = 1'b1;
    ifc.n_stall = 1'b0;
    tick();
    tick();
    resp_en = 1'b0;
    tick();
    tick();
    vectors++;
    if ({ifc.imem_req, ifc.imem_addr} !== {1'b0, 32'h10}) begin
      miscompares++;
      $display("FAIL redir_pending got req=%b addr=%h want 0 00000010", ifc.imem_req, ifc.imem_addr);
    end
    ifc.redirect = 1'b1;
    ifc.redirect_pc = 32'h0000_1003;
    resp_en = 1'b1;
    ifc.n_stall = 1'b1;
    tick();
    ifc.redirect = 1'b0;
    #1;
    vectors++;
    if ({ifc.n_irdy, ifc.imem_req, ifc.imem_addr} !== {1'b1, 1'b0, 32'h1000}) begin
      miscompares++;
      $display("FAIL redir_flush got nirdy=%b req=%b addr=%h want 1 0 00001000",
               ifc.n_irdy, ifc.imem_req, ifc.imem_addr);
    end
    tick();
    vectors++;
    if ({ifc.n_irdy, ifc.imem_req, ifc.imem_addr} !== {1'b1, 1'b1, 32'h1000}) begin
      miscompares++;
      $display("FAIL redir_drop1 got nirdy=%b req=%b addr=%h want 1 1 00001000",
               ifc.n_irdy, ifc.imem_req, ifc.imem_addr);
    end
    tick();
    vectors++;
    if ({ifc.n_irdy, ifc.imem_addr} !== {1'b1, 32'h1004}) begin
      miscompares++;
      $display("FAIL redir_drop2 got nirdy=%b addr=%h want 1 00001004", ifc.n_irdy, ifc.imem_addr);
    end
    tick();
    vectors++;
    if ({ifc.n_irdy, ifc.inst_pc, ifc.instruction} !== {1'b0, 32'h1000, 32'hA5A5_1000}) begin
      miscompares++;
      $display("FAIL redir_first got nirdy=%b pc=%h ins=%h want 0 00001000 a5a51000",
               ifc.n_irdy, ifc.inst_pc, ifc.instruction);
    end
  endtask

  task automatic test_fault();
    do_reset();
    err_addr = 32'h4;
    ifc.imem_gnt = 1'b1;
    tick();
    for (int k = 2; k <= 4; k++) begin
      tick();
      vectors++;
      if ({ifc.n_irdy, ifc.inst_pc, ifc.fetch_fault, ifc.instruction}
          !== {1'b0, 32'(4 * (k - 2)), (k == 3), 32'(4 * (k - 2)) ^ 32'hA5A5_0000}) begin
        miscompares++;
        $display("FAIL fault_k%0d got nirdy=%b pc=%h ff=%b ins=%h want 0 %h %b %h", k,
                 ifc.n_irdy, ifc.inst_pc, ifc.fetch_fault, ifc.instruction,
                 32'(4 * (k - 2)), (k == 3), 32'(4 * (k - 2)) ^ 32'hA5A5_0000);
      end
    end
    vectors++;
    if (ifc.imem_addr !== 32'h10) begin
      miscompares++;
      $display("FAIL fault_continue got addr=%h want 00000010", ifc.imem_addr);
    end
  endtask

  task automatic test_grant_stall();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 32'h0}) begin
        miscompares++;
        $display("FAIL nogrant_c%0d got req=%b addr=%h want 1 00000000", i, ifc.imem_req, ifc.imem_addr);
      end
    end
    ifc.imem_gnt = 1'b1;
    tick();
    ifc.imem_gnt = 1'b0;
    tick();
    vectors++;
    if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 32'h4}) begin
      miscompares++;
      $display("FAIL grant_once got req=%b addr=%h want 1 00000004", ifc.imem_req, ifc.imem_addr);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ifc.imem_gnt = 1'b1;
    ifc.n_stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if ({ifc.n_irdy, ifc.inst_pc, ifc.imem_req} !== {1'b0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_pre got nirdy=%b pc=%h req=%b want 0 00000000 0",
               ifc.n_irdy, ifc.inst_pc, ifc.imem_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.imem_gnt = 1'b0;
    #1;
    vectors++;
    if ({ifc.n_irdy, ifc.imem_req, ifc.imem_addr, ifc.instruction, ifc.inst_pc, ifc.fetch_fault}
        !== {1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_post got nirdy=%b req=%b addr=%h ins=%h pc=%h ff=%b want 1 1 0 0 0 0",
               ifc.n_irdy, ifc.imem_req, ifc.imem_addr, ifc.instruction, ifc.inst_pc, ifc.fetch_fault);
    end
    tick();
    vectors++;
    if (ifc.n_irdy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_empty got nirdy=%b want 1", ifc.n_irdy);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_fault();
    test_grant_stall();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
